// File: rtl/ifu_prefetch_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
interface ifu_prefetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Pipelined instruction fetch: multiple outstanding imem requests, FIFO prefetch queue, counted flush discard.
// Optional static branch prediction on queue push is enabled with IFU_STATIC_BP_EN.
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    ifu_prefetch_if.master   imem,
    input  logic             EXE_ready,
    input  logic             EXE_flush,
    input  logic [XLEN-1:0]  EXE_flush_addr,
    input  logic             INT_flush,
    input  logic [XLEN-1:0]  INT_flush_addr,
    input  logic             INT_PC_reload,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instruction,
    output logic [XLEN-1:0]  pc_to_EXE,
    output logic             addr_unaligned,
`ifdef IFU_STATIC_BP_EN
    output logic             bp_taken,
`endif
    output logic [XLEN-1:0]  PC
);
    localparam int QW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUT);
    localparam logic [AW-1:0] AF_LAST = AW'(MAX_OUT - 1);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count, out_cnt, drop_cnt, out_cnt_next;
    logic [QW-1:0]   head, tail;
    logic [AW-1:0]   af_wr, af_rd;
    logic            halt;

    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] af_addr [MAX_OUT];

    logic            flush, rsp_ok, rsp_keep, push, pop, req_valid, accept, redir;
    logic [XLEN-1:0] flush_addr, rsp_addr, redir_addr;

    assign flush      = INT_flush | EXE_flush;
    assign flush_addr = INT_flush ? INT_flush_addr : EXE_flush_addr;
    // A response with nothing in flight is a protocol error and is ignored entirely.
    assign rsp_ok     = imem.imem_rsp_valid && (out_cnt != '0);
    assign rsp_keep   = rsp_ok && (drop_cnt == '0) && !flush;
    assign rsp_addr   = af_addr[af_rd];
    assign push       = rsp_keep;
    assign pop        = instr_valid && EXE_ready;

`ifdef IFU_STATIC_BP_EN
    logic                   bp_hit;
    logic [XLEN-1:0]        bp_target;
    logic signed [20:0]     imm_j;
    logic signed [12:0]     imm_b;
    logic                   q_bp [DEPTH];

    always_comb begin
        imm_j     = {imem.imem_rsp_data[31], imem.imem_rsp_data[19:12], imem.imem_rsp_data[20],
                     imem.imem_rsp_data[30:21], 1'b0};
        imm_b     = {imem.imem_rsp_data[31], imem.imem_rsp_data[7], imem.imem_rsp_data[30:25],
                     imem.imem_rsp_data[11:8], 1'b0};
        bp_hit    = 1'b0;
        bp_target = rsp_addr;
        if (rsp_keep && imem.imem_rsp_data[6:0] == 7'b1101111) begin
            bp_hit    = 1'b1;
            bp_target = rsp_addr + XLEN'(imm_j);
        end else if (rsp_keep && imem.imem_rsp_data[6:0] == 7'b1100011 && imm_b < 0) begin
            bp_hit    = 1'b1;
            bp_target = rsp_addr + XLEN'(imm_b);
        end
    end

    assign redir      = flush | bp_hit;
    assign redir_addr = flush ? flush_addr : bp_target;
    assign bp_taken   = instr_valid && q_bp[head];
`else
    assign redir      = flush;
    assign redir_addr = flush_addr;
`endif

    // Credit rule: queued + in-flight never exceeds DEPTH, so a response always finds room.
    assign req_valid = !INT_PC_reload && !rst && (out_cnt < MAX_L)
                       && (({1'b0, count} + {1'b0, out_cnt}) < DEPTH_L)
                       && (drop_cnt == '0) && !halt && !redir;
    assign accept       = req_valid && imem.imem_req_ready;
    assign out_cnt_next = out_cnt + CW'(accept) - CW'(rsp_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            count          <= '0;
            head           <= '0;
            tail           <= '0;
            out_cnt        <= '0;
            drop_cnt       <= '0;
            af_wr          <= '0;
            af_rd          <= '0;
            halt           <= 1'b0;
            addr_unaligned <= 1'b0;
        end else begin
            addr_unaligned <= redir && (redir_addr[1:0] != 2'b00);
            out_cnt        <= out_cnt_next;
            if (accept) af_wr <= (af_wr == AF_LAST) ? '0 : af_wr + AW'(1);
            if (rsp_ok) af_rd <= (af_rd == AF_LAST) ? '0 : af_rd + AW'(1);
            // Everything still in flight after this cycle belongs to the old stream.
            if (redir) begin
                pc       <= redir_addr;
                drop_cnt <= out_cnt_next;
                halt     <= (redir_addr[1:0] != 2'b00);
            end else begin
                if (accept) pc <= pc + XLEN'(4);
                if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
            if (flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) tail <= tail + QW'(1);
                if (pop)  head <= head + QW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage: written on accept/push only, never reset.
    always_ff @(posedge clk) begin
        if (accept) af_addr[af_wr] <= pc;
        if (push) begin
            q_instr[tail] <= imem.imem_rsp_data;
            q_pc[tail]    <= rsp_addr;
`ifdef IFU_STATIC_BP_EN
            q_bp[tail]    <= bp_hit;
`endif
        end
    end

    assign instr_valid        = (count != '0);
    assign instruction        = instr_valid ? q_instr[head] : '0;
    assign pc_to_EXE          = instr_valid ? q_pc[head] : '0;
    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc;
    assign PC                 = pc;
endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: random imem latency/back-pressure, flushes and resets.
module tb_ifu_prefetch;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_ready, EXE_flush, INT_flush, INT_PC_reload;
    logic [31:0] EXE_flush_addr, INT_flush_addr;
    logic        instr_valid, addr_unaligned;
    logic [31:0] instruction, pc_to_EXE, PC;
`ifdef IFU_STATIC_BP_EN
    logic        bp_taken;
`endif

    always #5 clk = ~clk;

    ifu_prefetch_if #(.XLEN(XLEN)) imem ();

    ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .EXE_ready(EXE_ready), .EXE_flush(EXE_flush), .EXE_flush_addr(EXE_flush_addr),
        .INT_flush(INT_flush), .INT_flush_addr(INT_flush_addr), .INT_PC_reload(INT_PC_reload),
        .instr_valid(instr_valid), .instruction(instruction), .pc_to_EXE(pc_to_EXE),
        .addr_unaligned(addr_unaligned),
`ifdef IFU_STATIC_BP_EN
        .bp_taken(bp_taken),
`endif
        .PC(PC)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    exp_t        e;
    int          errors = 0, checks = 0;
    int          cyc = 0, min_lat = 1, max_lat = 1;
    int          acc_cnt = 0, deliv_cnt = 0;
    logic [31:0] exp_req = 32'h0, tgt, first_pc;
    bit          halted = 0, flushed_last = 0, first_seen = 0;

    // Memory image: never a branch/jump opcode, so fetch stays sequential in either build.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E3779B1) ^ 32'h5BD1E995;
        return {h[31:7], 7'b0010011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_first(input string name, input logic [31:0] exp);
        int n = 0;
        while (!first_seen && n < 40) begin
            tick(1);
            n++;
        end
        if (!first_seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no delivery within 40 cycles expected pc %h", name, exp);
        end else begin
            check(name, first_pc, exp);
        end
    endtask

    // In-order memory: answers each accepted request after its chosen latency.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = $urandom;
        end
    end

    // Monitor: deliveries against the scoreboard, requests against the sequential-fetch model.
    always @(negedge clk) begin
        if (rst) begin
            check("req_valid_in_reset", {31'b0, imem.imem_req_valid}, 32'd0);
            sb.delete();
            mq.delete();
            exp_req      = 32'h0;
            halted       = 0;
            flushed_last = 0;
            first_seen   = 0;
            acc_cnt      = 0;
        end else begin
            if (flushed_last) check("valid_after_flush", {31'b0, instr_valid}, 32'd0);
            if (instr_valid && EXE_ready) begin
                deliv_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got pc %h expected none", pc_to_EXE);
                end else begin
                    e = sb.pop_front();
                    check("pc_to_EXE", pc_to_EXE, e.pc);
                    check("instruction", instruction, e.ins);
                    if (!first_seen) begin
                        first_seen = 1;
                        first_pc   = pc_to_EXE;
                    end
                end
            end
            if (imem.imem_req_valid) begin
                if (halted || EXE_flush || INT_flush || INT_PC_reload) begin
                    checks++;
                    errors++;
                    $display("FAIL blocked_request: got request at %h expected none", imem.imem_req_addr);
                end else if (imem.imem_req_ready) begin
                    check("req_addr", imem.imem_req_addr, exp_req);
                    sb.push_back('{exp_req, mem_word(exp_req)});
                    mq.push_back('{imem.imem_req_addr, cyc + $urandom_range(min_lat, max_lat)});
                    exp_req += 32'd4;
                    acc_cnt++;
                end
            end
            flushed_last = INT_flush || EXE_flush;
            if (flushed_last) begin
                tgt        = INT_flush ? INT_flush_addr : EXE_flush_addr;
                sb.delete();
                exp_req    = tgt;
                halted     = (tgt[1:0] != 2'b00);
                first_seen = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; EXE_ready = 1'b1; imem.imem_req_ready = 1'b1; INT_PC_reload = 1'b0;
        EXE_flush = 1'b0; INT_flush = 1'b0; EXE_flush_addr = '0; INT_flush_addr = '0;
        tick(3);
        @(negedge clk);
        check("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_instruction", instruction, 32'd0);
        check("reset_pc_to_EXE", pc_to_EXE, 32'd0);
        check("reset_PC", PC, 32'd0);
        check("reset_unaligned", {31'b0, addr_unaligned}, 32'd0);

        // Streaming with a 1-cycle memory
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
        check("first_req_addr", imem.imem_req_addr, 32'h0);
        @(negedge clk);
        check("valid_1cyc_after_req", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        check("valid_2cyc_after_req", {31'b0, instr_valid}, 32'd1);
        check("first_pc_to_EXE", pc_to_EXE, 32'h0);
        d0 = deliv_cnt;
        tick(12);
        check("stream_progress", {31'b0, (deliv_cnt - d0) >= 8}, 32'd1);

        // Back-pressure: queue fills to DEPTH, then drains in order
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrun_reset_valid", {31'b0, instr_valid}, 32'd0);
        tick(1);
        rst = 1'b0; EXE_ready = 1'b0;
        tick(15);
        @(negedge clk);
        check("bp_accept_count", acc_cnt, DEPTH);
        check("bp_req_dropped", {31'b0, imem.imem_req_valid}, 32'd0);
        check("bp_head_pc", pc_to_EXE, 32'h0);
        tick(1);
        d0 = deliv_cnt;
        EXE_ready = 1'b1;
        tick(10);
        check("bp_drain", {31'b0, (deliv_cnt - d0) >= 6}, 32'd1);

        // Flush with requests in flight on a slow memory
        min_lat = 3; max_lat = 3;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(8);
        EXE_flush = 1'b1; EXE_flush_addr = 32'h100;
        tick(1);
        EXE_flush = 1'b0;
        wait_first("flush_first_pc", 32'h100);

        // INT_flush wins over a simultaneous EXE_flush
        tick(5);
        INT_flush = 1'b1; INT_flush_addr = 32'h200;
        EXE_flush = 1'b1; EXE_flush_addr = 32'h100;
        tick(1);
        INT_flush = 1'b0; EXE_flush = 1'b0;
        @(negedge clk);
        check("priority_PC", PC, 32'h200);
        wait_first("priority_first_pc", 32'h200);

        // Unaligned redirect: one-cycle flag, then fetch stays halted
        tick(3);
        EXE_flush = 1'b1; EXE_flush_addr = 32'h102;
        tick(1);
        EXE_flush = 1'b0;
        @(negedge clk);
        check("unaligned_pulse", {31'b0, addr_unaligned}, 32'd1);
        check("unaligned_PC", PC, 32'h102);
        @(negedge clk);
        check("unaligned_pulse_end", {31'b0, addr_unaligned}, 32'd0);
        tick(20);
        @(negedge clk);
        check("unaligned_no_valid", {31'b0, instr_valid}, 32'd0);
        check("unaligned_no_req", {31'b0, imem.imem_req_valid}, 32'd0);
        tick(1);
        EXE_flush = 1'b1; EXE_flush_addr = 32'h40;
        tick(1);
        EXE_flush = 1'b0;
        wait_first("resume_first_pc", 32'h40);

        // Random traffic
        min_lat = 1; max_lat = 3;
        for (int i = 0; i < 3000; i++) begin
            EXE_ready            = ($urandom_range(0, 3) != 0);
            imem.imem_req_ready  = ($urandom_range(0, 3) != 0);
            INT_PC_reload        = ($urandom_range(0, 9) == 0);
            rst                  = ($urandom_range(0, 599) == 0);
            EXE_flush            = 1'b0;
            INT_flush            = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
                case ($urandom_range(0, 2))
                    0: begin EXE_flush = 1'b1; EXE_flush_addr = tgt; end
                    1: begin INT_flush = 1'b1; INT_flush_addr = tgt; end
                    default: begin
                        EXE_flush = 1'b1; EXE_flush_addr = tgt ^ 32'h0000_1000;
                        INT_flush = 1'b1; INT_flush_addr = tgt;
                    end
                endcase
            end
            tick(1);
        end
        rst = 1'b0; EXE_flush = 1'b0; INT_flush = 1'b0; INT_PC_reload = 1'b0;
        EXE_ready = 1'b1; imem.imem_req_ready = 1'b1;
        d0 = deliv_cnt;
        tick(40);
        check("final_drain", {31'b0, (deliv_cnt - d0) >= 10}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
